// File: rtl/alu_sched_if.sv
// Handshake and datapath bundle for alu_sched: two request channels, the ALU
// operand/result path, the response channel and the status outputs.
interface alu_sched_if #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_res;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_res;
    logic             rsp_id;
    logic             rsp_err;

    logic             busy;
    logic [CNTW-1:0]  cnt0;
    logic [CNTW-1:0]  cnt1;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_res, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        output rsp_valid, rsp_res, rsp_id, rsp_err,
        output busy, cnt0, cnt1
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_res, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_res, rsp_id, rsp_err,
        input  busy, cnt0, cnt1
    );
endinterface

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one combinational ALU between two requesters;
// one operation in flight, result returned on a valid/ready channel.
module alu_sched #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic        clk,
    input  logic        rst,
    alu_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic             id_q, id_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
    logic [CNTW-1:0]  cnt_q [2];
    logic [CNTW-1:0]  cnt_d [2];

    logic             grant_any;
    logic             grant_id;
    logic [3:0]       grant_op;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0010, 4'b0000, 4'b0001, 4'b0110, 4'b0111: op_legal = 1'b1;
            default:                                     op_legal = 1'b0;
        endcase
    endfunction

    // With both requesters valid the pointer decides; otherwise whoever is valid wins.
    always_comb begin
        grant_any = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
        grant_id  = (bus.req0_valid && bus.req1_valid) ? ptr_q : bus.req1_valid;
        grant_op  = grant_id ? bus.req1_op : bus.req0_op;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        id_d      = id_q;
        err_d     = err_q;
        rsp_res_d = rsp_res_q;
        cnt_d[0]  = cnt_q[0];
        cnt_d[1]  = cnt_q[1];

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    a_d     = grant_id ? bus.req1_a : bus.req0_a;
                    b_d     = grant_id ? bus.req1_b : bus.req0_b;
                    op_d    = grant_op;
                    id_d    = grant_id;
                    err_d   = ~op_legal(grant_op);
                    ptr_d   = ~grant_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_res_d = err_q ? '0 : bus.alu_res;
                state_d   = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    cnt_d[id_q] = cnt_q[id_q] + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            id_q      <= 1'b0;
            err_q     <= 1'b0;
            rsp_res_q <= '0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            id_q      <= id_d;
            err_q     <= err_d;
            rsp_res_q <= rsp_res_d;
            cnt_q[0]  <= cnt_d[0];
            cnt_q[1]  <= cnt_d[1];
        end
    end

    // ALU inputs follow the operand latches, so they hold between operations.
    assign bus.req0_ready = grant_any && !grant_id;
    assign bus.req1_ready = grant_any && grant_id;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_res    = rsp_res_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_err    = err_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.cnt0       = cnt_q[0];
    assign bus.cnt1       = cnt_q[1];
endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: expected responses are queued at grant time
// and compared when the response handshake completes.
module tb_alu_sched;
    localparam int WIDTH = 32;
    localparam int CNTW  = 2;
    localparam int MASK  = (1 << CNTW) - 1;

    typedef struct {
        logic [31:0] res;
        logic        id;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_sched_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus();

    alu_sched #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   grant_log[$];
    int   cnt_m[2];
    int   checks = 0;
    int   errors = 0;
    int   n_rsp  = 0;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0010: alu_f = a + b;
            4'b0000: alu_f = a & b;
            4'b0001: alu_f = a | b;
            4'b0110: alu_f = a - b;
            4'b0111: alu_f = (a < b) ? 32'd1 : 32'd0;
            default: alu_f = a ^ b ^ 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic exp_t make_exp(input logic id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.id  = id;
        e.err = !(op == 4'b0010 || op == 4'b0000 || op == 4'b0001 || op == 4'b0110 || op == 4'b0111);
        e.res = e.err ? 32'd0 : alu_f(op, a, b);
        return e;
    endfunction

    // External ALU model; garbage for illegal opcodes so forced zero is visible.
    always_comb bus.alu_res = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_val("ready_exclusive", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
            check_val("cnt0_track", 64'(bus.cnt0), 64'(cnt_m[0] & MASK));
            check_val("cnt1_track", 64'(bus.cnt1), 64'(cnt_m[1] & MASK));
            if (bus.req0_ready) begin
                sb.push_back(make_exp(1'b0, bus.req0_op, bus.req0_a, bus.req0_b));
                grant_log.push_back(0);
                $display("grant id=0 op=%b a=%0h b=%0h", bus.req0_op, bus.req0_a, bus.req0_b);
            end
            if (bus.req1_ready) begin
                sb.push_back(make_exp(1'b1, bus.req1_op, bus.req1_a, bus.req1_b));
                grant_log.push_back(1);
                $display("grant id=1 op=%b a=%0h b=%0h", bus.req1_op, bus.req1_a, bus.req1_b);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                $display("rsp id=%0d res=%0h err=%0d", bus.rsp_id, bus.rsp_res, bus.rsp_err);
                if (sb.size() == 0) begin
                    check_val("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_val("rsp_res", 64'(bus.rsp_res), 64'(mon_e.res));
                    check_val("rsp_id", 64'(bus.rsp_id), 64'(mon_e.id));
                    check_val("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
                    cnt_m[mon_e.id ? 1 : 0]++;
                end
                n_rsp++;
            end
        end
    end

    task automatic clr_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst = 1'b1;
        sb.delete();
        grant_log.delete();
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_req(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
    endtask

    task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        int k;
        set_req(id, a, b, op);
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) break;
            k++;
        end
        if (k == 50) check_val("grant_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int k;
        k = 0;
        while (n_rsp < target && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (n_rsp < target) check_val("rsp_timeout", 64'(n_rsp), 64'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int c1;
        int k;
        int wrap_seq[4];
        logic [3:0] wrap_ops[4];
        wrap_seq = '{1, 2, 3, 0};
        wrap_ops = '{4'b0010, 4'b0000, 4'b0001, 4'b0111};

        bus.rsp_ready = 1'b1;
        do_reset();

        // Reset values
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_val("rst_alu_a", 64'(bus.alu_a), 64'd0);
        check_val("rst_alu_op", 64'(bus.alu_op), 64'd0);
        check_val("rst_rsp_res", 64'(bus.rsp_res), 64'd0);
        check_val("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        check_val("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check_val("rst_ready0", 64'(bus.req0_ready), 64'd0);

        // Single add with latency checks
        base = n_rsp;
        set_req(1'b0, 32'd5, 32'd3, 4'b0010);
        @(negedge clk);
        check_val("add_ready0_T", 64'(bus.req0_ready), 64'd1);
        check_val("add_ready1_T", 64'(bus.req1_ready), 64'd0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        check_val("add_alu_a_T1", 64'(bus.alu_a), 64'd5);
        check_val("add_alu_b_T1", 64'(bus.alu_b), 64'd3);
        check_val("add_alu_op_T1", 64'(bus.alu_op), 64'd2);
        check_val("add_busy_T1", 64'(bus.busy), 64'd1);
        check_val("add_rsp_valid_T1", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk); #1;
        check_val("add_rsp_valid_T2", 64'(bus.rsp_valid), 64'd1);
        check_val("add_rsp_res_T2", 64'(bus.rsp_res), 64'd8);
        wait_rsp(base + 1);
        check_val("add_cnt0", 64'(bus.cnt0), 64'd1);
        check_val("add_alu_a_hold", 64'(bus.alu_a), 64'd5);

        // Contention: both valid continuously, pointer fresh from reset
        do_reset();
        base = n_rsp;
        set_req(1'b0, 32'd10, 32'd4, 4'b0110);
        set_req(1'b1, 32'h0000_F0F0, 32'h0000_0FF0, 4'b0000);
        k = 0;
        while (grant_log.size() < 4 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_rsp(base + 4);
        check_val("cont_grants", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) check_val("cont_order", 64'(grant_log[i]), 64'(i % 2));
        end
        check_val("cont_cnt0", 64'(bus.cnt0), 64'd2);
        check_val("cont_cnt1", 64'(bus.cnt1), 64'd2);

        // Backpressure: response held for 5 cycles, then next grant one cycle after handshake
        base = n_rsp;
        bus.rsp_ready = 1'b0;
        issue(1'b0, 32'd100, 32'd23, 4'b0010);
        k = 0;
        while (!bus.rsp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        set_req(1'b1, 32'd1, 32'd2, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            check_val("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check_val("bp_rsp_res", 64'(bus.rsp_res), 64'd123);
            check_val("bp_rsp_id", 64'(bus.rsp_id), 64'd0);
            check_val("bp_rsp_err", 64'(bus.rsp_err), 64'd0);
            check_val("bp_busy", 64'(bus.busy), 64'd1);
            check_val("bp_ready0", 64'(bus.req0_ready), 64'd0);
            check_val("bp_ready1", 64'(bus.req1_ready), 64'd0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_val("bp_next_grant", 64'(bus.req1_ready), 64'd1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        wait_rsp(base + 2);

        // Illegal opcode
        base = n_rsp;
        c1 = cnt_m[1];
        issue(1'b1, 32'd7, 32'd9, 4'b1111);
        wait_rsp(base + 1);
        check_val("ill_cnt1", 64'(bus.cnt1), 64'((c1 + 1) & MASK));

        // Reset during EXEC drops the transaction
        set_req(1'b0, 32'd1, 32'd1, 4'b0010);
        @(negedge clk);
        check_val("rmid_grant", 64'(bus.req0_ready), 64'd1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        check_val("rmid_busy_exec", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        sb.delete();
        grant_log.delete();
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        check_val("rmid_busy", 64'(bus.busy), 64'd0);
        check_val("rmid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_val("rmid_alu_a", 64'(bus.alu_a), 64'd0);
        check_val("rmid_alu_b", 64'(bus.alu_b), 64'd0);
        check_val("rmid_cnt0", 64'(bus.cnt0), 64'd0);
        check_val("rmid_cnt1", 64'(bus.cnt1), 64'd0);
        check_val("rmid_rsp_res", 64'(bus.rsp_res), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        base = n_rsp;
        set_req(1'b1, 32'h20, 32'h3, 4'b0110);
        @(negedge clk);
        check_val("rmid_req1_grant", 64'(bus.req1_ready), 64'd1);
        check_val("rmid_req0_idle", 64'(bus.req0_ready), 64'd0);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        wait_rsp(base + 1);

        // Counter wrap with CNTW=2
        do_reset();
        for (int i = 0; i < 4; i++) begin
            base = n_rsp;
            issue(1'b0, 32'(i * 3 + 1), 32'd2, wrap_ops[i]);
            wait_rsp(base + 1);
            check_val("wrap_cnt0", 64'(bus.cnt0), 64'(wrap_seq[i]));
        end

        check_val("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
